// File: rtl/num_parse_if.sv
`default_nettype none
// ============================================================================
// Module      : num_parse_if
// Description : Bundle of the number-parser request/result handshake and its
//               8-bit memory read bus.
//               slave  modport : parser side (num_parse_ctl)
//               master modport : interpreter + memory side
//               Signals: req, hex, tib          - request (master -> slave)
//                        mem_rd, mem_addr       - read strobe/address (slave -> master)
//                        mem_dat                - read data, 1-cycle latency
//                        bsy, done, ok, vo, nxt - status and result
// Revision    : 1.0 - initial release
// ============================================================================
interface num_parse_if #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
);
  logic           req;
  logic           hex;
  logic [ASZ-1:0] tib;
  logic           mem_rd;
  logic [ASZ-1:0] mem_addr;
  logic [7:0]     mem_dat;
  logic           bsy;
  logic           done;
  logic           ok;
  logic [DSZ-1:0] vo;
  logic [ASZ-1:0] nxt;

  modport master (
    output req, hex, tib, mem_dat,
    input  mem_rd, mem_addr, bsy, done, ok, vo, nxt
  );

  modport slave (
    input  req, hex, tib, mem_dat,
    output mem_rd, mem_addr, bsy, done, ok, vo, nxt
  );
endinterface
`default_nettype wire

// File: rtl/num_parse_ctl.sv
`default_nettype none
// ============================================================================
// Module      : num_parse_ctl
// Description : Forth number-conversion sequencer. Walks the terminal input
//               buffer over the memory bus, skips leading spaces, accepts an
//               optional '-', then accumulates decimal or hex digits until a
//               space, NUL or the per-request character limit.
//               Ports: clk   - clock, rising edge
//                      rst_n - synchronous active-low reset
//                      bus   - num_parse_if.slave (request, memory, result)
// Revision    : 1.0 - initial release
// ============================================================================
module num_parse_ctl #(
  parameter int ASZ  = 17,
  parameter int DSZ  = 32,
  parameter int MAXC = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  num_parse_if.slave  bus
);

  localparam int CW = $clog2(MAXC + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SKIP_RD = 3'd1;
  localparam logic [2:0] S_SKIP_EV = 3'd2;
  localparam logic [2:0] S_NUM_RD  = 3'd3;
  localparam logic [2:0] S_NUM_EV  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  logic [2:0]     state;
  logic           hex_m;
  logic           neg;
  logic [DSZ-1:0] acc;
  logic [CW-1:0]  dcnt;
  logic [CW-1:0]  rcnt;
  logic [ASZ-1:0] mem_addr;
  logic           ok;
  logic [DSZ-1:0] vo;
  logic [ASZ-1:0] nxt;

  // Digit decode of the byte returned by the previous read
  logic           dig_ok;
  logic [3:0]     dig_val;
  logic [DSZ-1:0] acc_dig;

  always_comb begin
    dig_ok  = 1'b0;
    dig_val = 4'd0;
    if (bus.mem_dat >= 8'h30 && bus.mem_dat <= 8'h39) begin
      dig_ok  = 1'b1;
      dig_val = bus.mem_dat[3:0];
    end else if (hex_m && ((bus.mem_dat >= 8'h61 && bus.mem_dat <= 8'h66) ||
                           (bus.mem_dat >= 8'h41 && bus.mem_dat <= 8'h46))) begin
      // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
      dig_ok  = 1'b1;
      dig_val = bus.mem_dat[3:0] + 4'd9;
    end
  end

  assign acc_dig = (hex_m ? {acc[DSZ-5:0], 4'h0} : acc * DSZ'(10)) + DSZ'(dig_val);

  // Evaluation of one character in SKIP_EV / NUM_EV
  logic           ev_cont;   // character consumed, another read wanted
  logic           ev_ok;     // ok value when terminating on this character
  logic           ev_neg;
  logic [DSZ-1:0] ev_acc;
  logic [CW-1:0]  ev_dcnt;
  logic [2:0]     ev_rd;     // read state to continue in
  logic           at_limit;  // this character is the MAXC-th read
  logic           lim_ok;

  always_comb begin
    ev_cont = 1'b0;
    ev_ok   = 1'b0;
    ev_neg  = neg;
    ev_acc  = acc;
    ev_dcnt = dcnt;
    ev_rd   = S_NUM_RD;
    if (bus.mem_dat == CH_SP) begin
      if (state == S_SKIP_EV) begin
        ev_cont = 1'b1;
        ev_rd   = S_SKIP_RD;
      end else begin
        ev_ok = (dcnt != '0);
      end
    end else if (bus.mem_dat == CH_NUL) begin
      // In SKIP_EV no digit has been seen, so this yields ok=0 there
      ev_ok = (dcnt != '0);
    end else if (dig_ok) begin
      ev_cont = 1'b1;
      ev_acc  = acc_dig;
      ev_dcnt = dcnt + CW'(1);
    end else if (bus.mem_dat == CH_MINUS && state == S_SKIP_EV) begin
      ev_cont = 1'b1;
      ev_neg  = 1'b1;
    end
    at_limit = (rcnt == CW'(MAXC - 1));
    lim_ok   = (ev_dcnt != '0) && (state == S_NUM_EV);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hex_m    <= 1'b0;
      neg      <= 1'b0;
      acc      <= '0;
      dcnt     <= '0;
      rcnt     <= '0;
      mem_addr <= '0;
      ok       <= 1'b0;
      vo       <= '0;
      nxt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            hex_m    <= bus.hex;
            mem_addr <= bus.tib;
            acc      <= '0;
            neg      <= 1'b0;
            dcnt     <= '0;
            rcnt     <= '0;
            vo       <= '0;
            ok       <= 1'b0;
            state    <= S_SKIP_RD;
          end
        end
        S_SKIP_RD: state <= S_SKIP_EV;
        S_NUM_RD:  state <= S_NUM_EV;
        S_SKIP_EV, S_NUM_EV: begin
          rcnt <= rcnt + CW'(1);
          neg  <= ev_neg;
          acc  <= ev_acc;
          dcnt <= ev_dcnt;
          if (ev_cont) begin
            mem_addr <= mem_addr + ASZ'(1);
          end
          if (ev_cont && !at_limit) begin
            state <= ev_rd;
          end else begin
            // Terminator: nxt points at it. Limit: nxt is one past the
            // last character read, i.e. tib+MAXC.
            state <= S_DONE;
            ok    <= ev_cont ? lim_ok : ev_ok;
            vo    <= ev_neg ? -ev_acc : ev_acc;
            nxt   <= ev_cont ? mem_addr + ASZ'(1) : mem_addr;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd   = (state == S_SKIP_RD) || (state == S_NUM_RD);
  assign bus.mem_addr = mem_addr;
  assign bus.bsy      = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.ok       = ok;
  assign bus.vo       = vo;
  assign bus.nxt      = nxt;

endmodule
`default_nettype wire

// File: tb/tb_num_parse_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_num_parse_ctl
// Description : Directed self-checking bench for num_parse_ctl with a
//               byte-wide memory model of 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_num_parse_ctl;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;
  int   cyc;

  logic [7:0]  mem [0:131071];
  logic [16:0] rd_addr_q[$];
  int          rd_cyc_q[$];

  num_parse_if #(.ASZ(17), .DSZ(32)) bus ();

  num_parse_ctl #(.ASZ(17), .DSZ(32), .MAXC(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_dat <= mem[bus.mem_addr];
      rd_addr_q.push_back(bus.mem_addr);
      rd_cyc_q.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic load(input logic [16:0] a, input string s);
    for (int i = 0; i < 64; i++) mem[int'(a) + i] = 8'h00;
    for (int i = 0; i < s.len(); i++) mem[int'(a) + i] = s[i];
  endtask

  // Returns one cycle into the request (cycle 1 after the req cycle), +1ns
  task automatic start_req(input logic h, input logic [16:0] a);
    @(posedge clk); #1;
    rd_addr_q.delete();
    rd_cyc_q.delete();
    bus.req = 1'b1;
    bus.hex = h;
    bus.tib = a;
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  // lat = cycle index (req cycle = 0) in which done is seen; -1 on timeout.
  // A stray req is pulsed in cycle pulse_at (0 disables).
  task automatic wait_done(input int pulse_at, output int lat);
    lat = 1;
    while (1) begin
      if (pulse_at != 0 && lat == pulse_at) begin
        bus.req = 1'b1; bus.hex = 1'b1; bus.tib = 17'h00300;
      end else begin
        bus.req = 1'b0;
      end
      @(negedge clk);
      if (bus.done) break;
      lat++;
      if (lat > 200) begin lat = -1; break; end
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.req = 1'b0; bus.hex = 1'b0; bus.tib = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++; if (bus.bsy !== 1'b0) begin errs++; $display("FAIL reset_bsy: got %0b expected 0", bus.bsy); end
    vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
    vecs++; if (bus.ok !== 1'b0) begin errs++; $display("FAIL reset_ok: got %0b expected 0", bus.ok); end
    vecs++; if (bus.mem_rd !== 1'b0) begin errs++; $display("FAIL reset_mem_rd: got %0b expected 0", bus.mem_rd); end
    vecs++; if (bus.vo !== 32'h0) begin errs++; $display("FAIL reset_vo: got %0h expected 0", bus.vo); end
    vecs++; if (bus.nxt !== 17'h0) begin errs++; $display("FAIL reset_nxt: got %0h expected 0", bus.nxt); end
    vecs++; if (bus.mem_addr !== 17'h0) begin errs++; $display("FAIL reset_mem_addr: got %0h expected 0", bus.mem_addr); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_decimal;
    int lat;
    load(17'h00100, "123");
    start_req(1'b0, 17'h00100);
    vecs++; if (bus.bsy !== 1'b1) begin errs++; $display("FAIL dec_bsy_rise: got %0b expected 1", bus.bsy); end
    wait_done(0, lat);
    vecs++; if (lat !== 9) begin errs++; $display("FAIL dec_latency: got %0d expected 9", lat); end
    vecs++; if (bus.ok !== 1'b1) begin errs++; $display("FAIL dec_ok: got %0b expected 1", bus.ok); end
    vecs++; if (bus.vo !== 32'd123) begin errs++; $display("FAIL dec_vo: got %0h expected 7b", bus.vo); end
    vecs++; if (bus.nxt !== 17'h00103) begin errs++; $display("FAIL dec_nxt: got %0h expected 103", bus.nxt); end
    vecs++; if (rd_addr_q.size() !== 4) begin errs++; $display("FAIL dec_rd_count: got %0d expected 4", rd_addr_q.size()); end
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
      vecs++;
      if (rd_addr_q[i] !== 17'(17'h00100 + i)) begin errs++; $display("FAIL dec_rd_addr%0d: got %0h expected %0h", i, rd_addr_q[i], 17'h00100 + i); end
      vecs++;
      if (rd_cyc_q[i] - rd_cyc_q[0] !== 2 * i) begin errs++; $display("FAIL dec_rd_spacing%0d: got %0d expected %0d", i, rd_cyc_q[i] - rd_cyc_q[0], 2 * i); end
    end
    @(posedge clk); #1;
    vecs++; if (bus.bsy !== 1'b0) begin errs++; $display("FAIL dec_bsy_fall: got %0b expected 0", bus.bsy); end
    vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL dec_done_pulse: got %0b expected 0", bus.done); end
  endtask

  task automatic test_sign;
    int lat;
    load(17'h00200, "  -45 ");
    start_req(1'b0, 17'h00200);
    wait_done(0, lat);
    vecs++; if (lat !== 13) begin errs++; $display("FAIL sign_latency: got %0d expected 13", lat); end
    vecs++; if (bus.ok !== 1'b1) begin errs++; $display("FAIL sign_ok: got %0b expected 1", bus.ok); end
    vecs++; if (bus.vo !== 32'hFFFFFFD3) begin errs++; $display("FAIL sign_vo: got %0h expected ffffffd3", bus.vo); end
    vecs++; if (bus.nxt !== 17'h00205) begin errs++; $display("FAIL sign_nxt: got %0h expected 205", bus.nxt); end
  endtask

  task automatic test_hex;
    int lat;
    load(17'h00300, "fF");
    start_req(1'b1, 17'h00300);
    wait_done(0, lat);
    vecs++; if (lat !== 7) begin errs++; $display("FAIL hex_latency: got %0d expected 7", lat); end
    vecs++; if (bus.ok !== 1'b1) begin errs++; $display("FAIL hex_ok: got %0b expected 1", bus.ok); end
    vecs++; if (bus.vo !== 32'hFF) begin errs++; $display("FAIL hex_vo: got %0h expected ff", bus.vo); end
    vecs++; if (bus.nxt !== 17'h00302) begin errs++; $display("FAIL hex_nxt: got %0h expected 302", bus.nxt); end
    start_req(1'b0, 17'h00300);
    wait_done(0, lat);
    vecs++; if (lat !== 3) begin errs++; $display("FAIL hexdec_latency: got %0d expected 3", lat); end
    vecs++; if (bus.ok !== 1'b0) begin errs++; $display("FAIL hexdec_ok: got %0b expected 0", bus.ok); end
    vecs++; if (bus.vo !== 32'h0) begin errs++; $display("FAIL hexdec_vo: got %0h expected 0", bus.vo); end
    vecs++; if (bus.nxt !== 17'h00300) begin errs++; $display("FAIL hexdec_nxt: got %0h expected 300", bus.nxt); end
  endtask

  task automatic test_errors;
    int lat;
    load(17'h00400, "-");
    start_req(1'b0, 17'h00400);
    wait_done(0, lat);
    vecs++; if (lat !== 5) begin errs++; $display("FAIL minus_latency: got %0d expected 5", lat); end
    vecs++; if (bus.ok !== 1'b0) begin errs++; $display("FAIL minus_ok: got %0b expected 0", bus.ok); end
    vecs++; if (bus.nxt !== 17'h00401) begin errs++; $display("FAIL minus_nxt: got %0h expected 401", bus.nxt); end
    load(17'h00500, "12x ");
    start_req(1'b0, 17'h00500);
    wait_done(0, lat);
    vecs++; if (lat !== 7) begin errs++; $display("FAIL badch_latency: got %0d expected 7", lat); end
    vecs++; if (bus.ok !== 1'b0) begin errs++; $display("FAIL badch_ok: got %0b expected 0", bus.ok); end
    vecs++; if (bus.vo !== 32'd12) begin errs++; $display("FAIL badch_vo: got %0h expected c", bus.vo); end
    vecs++; if (bus.nxt !== 17'h00502) begin errs++; $display("FAIL badch_nxt: got %0h expected 502", bus.nxt); end
    load(17'h00600, "");
    start_req(1'b0, 17'h00600);
    wait_done(0, lat);
    vecs++; if (lat !== 3) begin errs++; $display("FAIL empty_latency: got %0d expected 3", lat); end
    vecs++; if (bus.ok !== 1'b0) begin errs++; $display("FAIL empty_ok: got %0b expected 0", bus.ok); end
    vecs++; if (bus.vo !== 32'h0) begin errs++; $display("FAIL empty_vo: got %0h expected 0", bus.vo); end
  endtask

  task automatic test_wrap_limit;
    int    lat;
    string s;
    load(17'h00700, "123456789");
    start_req(1'b1, 17'h00700);
    wait_done(0, lat);
    vecs++; if (lat !== 21) begin errs++; $display("FAIL wrap_latency: got %0d expected 21", lat); end
    vecs++; if (bus.ok !== 1'b1) begin errs++; $display("FAIL wrap_ok: got %0b expected 1", bus.ok); end
    vecs++; if (bus.vo !== 32'h23456789) begin errs++; $display("FAIL wrap_vo: got %0h expected 23456789", bus.vo); end
    s = "";
    for (int i = 0; i < 40; i++) s = {s, "a"};
    load(17'h00800, s);
    start_req(1'b1, 17'h00800);
    wait_done(0, lat);
    vecs++; if (lat !== 63) begin errs++; $display("FAIL limit_latency: got %0d expected 63", lat); end
    vecs++; if (bus.ok !== 1'b1) begin errs++; $display("FAIL limit_ok: got %0b expected 1", bus.ok); end
    vecs++; if (bus.nxt !== 17'h0081F) begin errs++; $display("FAIL limit_nxt: got %0h expected 81f", bus.nxt); end
    vecs++; if (bus.vo !== 32'hAAAAAAAA) begin errs++; $display("FAIL limit_vo: got %0h expected aaaaaaaa", bus.vo); end
  endtask

  task automatic test_reset_mid;
    bit seen_done;
    load(17'h00A00, "123456 ");
    start_req(1'b0, 17'h00A00);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vecs++; if (bus.bsy !== 1'b0) begin errs++; $display("FAIL rstmid_bsy: got %0b expected 0", bus.bsy); end
    vecs++; if (bus.vo !== 32'h0) begin errs++; $display("FAIL rstmid_vo: got %0h expected 0", bus.vo); end
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    vecs++; if (seen_done !== 1'b0) begin errs++; $display("FAIL rstmid_done: got %0b expected 0", seen_done); end
  endtask

  task automatic test_back_to_back;
    int lat;
    load(17'h00B00, "123");
    start_req(1'b0, 17'h00B00);
    wait_done(3, lat);
    vecs++; if (lat !== 9) begin errs++; $display("FAIL busyreq_latency: got %0d expected 9", lat); end
    vecs++; if (bus.ok !== 1'b1) begin errs++; $display("FAIL busyreq_ok: got %0b expected 1", bus.ok); end
    vecs++; if (bus.vo !== 32'd123) begin errs++; $display("FAIL busyreq_vo: got %0h expected 7b", bus.vo); end
    vecs++; if (bus.nxt !== 17'h00B03) begin errs++; $display("FAIL busyreq_nxt: got %0h expected b03", bus.nxt); end
    repeat (2) begin @(posedge clk); #1; end
    vecs++; if (bus.bsy !== 1'b0) begin errs++; $display("FAIL busyreq_idle: got %0b expected 0", bus.bsy); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_decimal();
    test_sign();
    test_hex();
    test_errors();
    test_wrap_limit();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
